simpleuart_rx: RTL and testbench

Serial receiver for the 8051 SFR bus; the counterpart of the `simpleuart` transmitter. It deserialises frames from the `rx` pin using the same bit-period divisor and bit order as the transmitter, so a looped-back `tx` is received byte-exact. It holds one received byte plus status flags, which the CPU reads through the SFR read port.

---
 rtl/simpleuart_pkg.sv | 27 ++
 rtl/simpleuart_rx_sync.sv | 22 ++
 rtl/simpleuart_rx.sv | 130 +++++++++++++
 tb/tb_simpleuart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/simpleuart_pkg.sv
// Shared definitions for the simpleuart transmitter and receiver:
// FSM state encodings and status-register bit positions.
package simpleuart_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'b00,
        STATE_START = 2'b01,
        STATE_BITS  = 2'b10,
        STATE_STOP  = 2'b11
    } uart_state_t;

    localparam int STAT_VALID = 0;
    localparam int STAT_OVR   = 1;
    localparam int STAT_FERR  = 2;

    function automatic logic [7:0] status_byte(input logic valid,
                                               input logic ovr,
                                               input logic ferr);
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_VALID] = valid;
        s[STAT_OVR]   = ovr;
        s[STAT_FERR]  = ferr;
        return s;
    endfunction

endpackage

// File: rtl/simpleuart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle level (1)
// so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic iclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge iclk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/simpleuart_rx.sv
// UART receiver on the 8051 SFR bus: 8N1, MSB first, one holding register
// with sticky overrun / framing-error status readable at SFR_ADDRESS+1.
module simpleuart_rx
    import simpleuart_pkg::*;
#(
    parameter logic [7:0] SFR_ADDRESS  = 8'h90,
    parameter logic [7:0] BAUD_DIVISOR = 8'h02
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ram_rd_en_sfr,
    input  logic [7:0] ram_rd_addr,
    output logic [7:0] ram_rd_byte,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic [1:0] state
);

    localparam logic [7:0] HALF      = BAUD_DIVISOR >> 1;
    localparam logic [7:0] STAT_ADDR = SFR_ADDRESS + 8'd1;

    uart_state_t st;
    logic        rxs;
    logic [7:0]  cnt;
    logic [2:0]  bitn;
    logic [7:0]  shreg;
    logic [7:0]  holding;
    logic        brk;
    logic        rd_data;
    logic        rd_stat;

    uart_rx_sync u_sync (
        .iclk (iclk),
        .rst  (rst),
        .d    (rx),
        .q    (rxs)
    );

    assign rd_data = ram_rd_en_sfr && (ram_rd_addr == SFR_ADDRESS);
    assign rd_stat = ram_rd_en_sfr && (ram_rd_addr == STAT_ADDR);
    assign state   = st;

    // Read clears are written first so a same-cycle completion or error overrides them.
    always_ff @(posedge iclk) begin
        if (rst) begin
            st         <= STATE_IDLE;
            cnt        <= 8'd0;
            bitn       <= 3'd0;
            shreg      <= 8'h00;
            holding    <= 8'h00;
            brk        <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rd_data) rx_valid <= 1'b0;
            if (rd_stat) begin
                frame_err  <= 1'b0;
                rx_overrun <= 1'b0;
            end
            case (st)
                STATE_IDLE: begin
                    cnt <= 8'd0;
                    brk <= 1'b0;
                    if (!rxs) st <= STATE_START;
                end
                STATE_START: begin
                    if (cnt == HALF) begin
                        cnt <= 8'd0;
                        if (!rxs) begin
                            st   <= STATE_BITS;
                            bitn <= 3'd0;
                        end else begin
                            st <= STATE_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STATE_BITS: begin
                    if (cnt == BAUD_DIVISOR) begin
                        cnt   <= 8'd0;
                        shreg <= {shreg[6:0], rxs};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) st <= STATE_STOP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STATE_STOP: begin
                    // brk: stop bit was low; wait for the line to return high
                    if (brk) begin
                        if (rxs) begin
                            st  <= STATE_IDLE;
                            brk <= 1'b0;
                        end
                    end else if (cnt == BAUD_DIVISOR) begin
                        cnt <= 8'd0;
                        if (rxs) begin
                            st <= STATE_IDLE;
                            if (!rx_valid || rd_data) begin
                                holding  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: st <= STATE_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_rd_byte = 8'h00;
        if (ram_rd_addr == SFR_ADDRESS)
            ram_rd_byte = holding;
        else if (ram_rd_addr == STAT_ADDR)
            ram_rd_byte = status_byte(rx_valid, rx_overrun, frame_err);
    end

endmodule

// File: tb/tb_simpleuart_rx.sv
// Bench for simpleuart_rx: bit-level TX model drives rx, a queue of expected bytes
// is checked by a monitor whenever rx_valid rises; directed cases check flags.
module tb_simpleuart_rx;

    localparam logic [7:0] ADDR = 8'h90;
    localparam logic [7:0] DIV  = 8'd4;
    localparam int         P    = 5;

    logic       iclk = 1'b0;
    logic       rst  = 1'b1;
    logic       rx   = 1'b1;
    logic       ram_rd_en_sfr = 1'b0;
    logic [7:0] ram_rd_addr   = ADDR;
    logic [7:0] ram_rd_byte;
    logic       rx_valid, rx_overrun, frame_err;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       valid_q = 1'b0;

    simpleuart_rx #(.SFR_ADDRESS(ADDR), .BAUD_DIVISOR(DIV)) dut (
        .iclk          (iclk),
        .rst           (rst),
        .rx            (rx),
        .ram_rd_en_sfr (ram_rd_en_sfr),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_byte   (ram_rd_byte),
        .rx_valid      (rx_valid),
        .rx_overrun    (rx_overrun),
        .frame_err     (frame_err),
        .state         (state)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each new byte (rx_valid rising) must match the head of the queue.
    always @(negedge iclk) begin
        #2;
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            if (rx_valid && !valid_q) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h expected none", ram_rd_byte);
                end else begin
                    chk("rx_byte", ram_rd_byte, exp_q.pop_front());
                end
            end
            valid_q <= rx_valid;
        end
    end

    // Transmitter model: start, 8 bits MSB first, stop for stop_bits periods,
    // plus one idle period when the stop level is high. All periods are P cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
        @(negedge iclk);
        rx = 1'b0;
        repeat (P) @(negedge iclk);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            repeat (P) @(negedge iclk);
        end
        rx = stop;
        repeat (P * stop_bits) @(negedge iclk);
        if (stop) repeat (P) @(negedge iclk);
    endtask

    task automatic sfr_read(input logic [7:0] a, input logic strobe, output logic [7:0] d);
        @(negedge iclk);
        ram_rd_addr   = a;
        ram_rd_en_sfr = strobe;
        #1 d = ram_rd_byte;
        @(negedge iclk);
        ram_rd_en_sfr = 1'b0;
        ram_rd_addr   = ADDR;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic       m_valid, m_ovr;
        logic [7:0] m_hold;

        repeat (4) @(negedge iclk);
        rst = 1'b0;
        @(negedge iclk);
        chk("reset_state", {6'b0, state}, 8'h00);
        chk("reset_flags", {5'b0, frame_err, rx_overrun, rx_valid}, 8'h00);
        sfr_read(ADDR, 1'b0, d);
        chk("reset_data", d, 8'h00);

        // Loopback A5
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1);
        chk("lb_valid", {7'b0, rx_valid}, 8'h01);
        sfr_read(ADDR, 1'b1, d);
        chk("lb_data", d, 8'hA5);
        chk("lb_valid_clr", {7'b0, rx_valid}, 8'h00);

        // Glitch: one cycle low
        @(negedge iclk); rx = 1'b0;
        @(negedge iclk); rx = 1'b1;
        repeat (2) @(negedge iclk);
        chk("glitch_start", {6'b0, state}, 8'h01);
        repeat (5) @(negedge iclk);
        chk("glitch_idle", {6'b0, state}, 8'h00);
        chk("glitch_flags", {5'b0, frame_err, rx_overrun, rx_valid}, 8'h00);

        // Overrun: 12 then 34 unread
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1);
        sfr_read(ADDR, 1'b0, d);
        chk("ovr_data", d, 8'h12);
        sfr_read(ADDR + 8'd1, 1'b1, d);
        chk("ovr_stat1", d, 8'h03);
        sfr_read(ADDR + 8'd1, 1'b1, d);
        chk("ovr_stat2", d, 8'h01);
        sfr_read(ADDR, 1'b1, d);
        chk("ovr_stat3", {7'b0, rx_valid}, 8'h00);

        // Framing error with 20 bit-times of break
        send_frame(8'h5A, 1'b0, 21);
        chk("ferr_state", {6'b0, state}, 8'h03);
        chk("ferr_flags", {5'b0, frame_err, rx_overrun, rx_valid}, 8'h04);
        rx = 1'b1;
        repeat (6) @(negedge iclk);
        chk("ferr_idle", {6'b0, state}, 8'h00);
        sfr_read(ADDR + 8'd1, 1'b1, d);
        chk("ferr_stat", d, 8'h04);
        sfr_read(ADDR + 8'd1, 1'b0, d);
        chk("ferr_stat_clr", d, 8'h00);

        // Completion during read: 77 held unread, C3 completes as data is read
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1);
        fork
            send_frame(8'hC3, 1'b1, 1);
            begin
                @(negedge iclk);
                repeat (50) @(posedge iclk);
                @(negedge iclk);
                ram_rd_en_sfr = 1'b1;
                @(posedge iclk);
                @(negedge iclk);
                ram_rd_en_sfr = 1'b0;
            end
        join
        #1;
        chk("cdr_valid", {7'b0, rx_valid}, 8'h01);
        chk("cdr_data", ram_rd_byte, 8'hC3);
        chk("cdr_ovr", {7'b0, rx_overrun}, 8'h00);

        // Reset during bit 4 of FF (rx_valid still set from C3)
        fork
            send_frame(8'hFF, 1'b1, 1);
            begin
                @(negedge iclk);
                repeat (P * 5 + 2) @(negedge iclk);
                rst = 1'b1;
                @(negedge iclk);
                #1;
                chk("rst_state", {6'b0, state}, 8'h00);
                chk("rst_flags", {5'b0, frame_err, rx_overrun, rx_valid}, 8'h00);
                chk("rst_data", ram_rd_byte, 8'h00);
                rst = 1'b0;
            end
        join
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1);
        sfr_read(ADDR, 1'b1, d);
        chk("rst_next", d, 8'h3C);

        // Random traffic with an abstract holding-register model
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_hold  = 8'h3C;
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom_range(0, 255));
            if (m_valid) begin
                m_ovr = 1'b1;
            end else begin
                exp_q.push_back(b);
                m_valid = 1'b1;
                m_hold  = b;
            end
            send_frame(b, 1'b1, 1);
            sfr_read(ADDR + 8'd1, 1'b1, d);
            chk("rnd_stat", d, {6'b0, m_ovr, m_valid});
            m_ovr = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                sfr_read(ADDR, 1'b1, d);
                chk("rnd_data", d, m_hold);
                m_valid = 1'b0;
            end
            repeat ($urandom_range(0, 7)) @(negedge iclk);
        end

        repeat (4) @(negedge iclk);
        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
